pwm_multi_channel: RTL

//  Parametrised multi-channel PWM generator; successor to the single-output, fixed 5-bit-duty PWM top.
//  One shared prescaler and period counter drive CHANNELS independent duty comparators.

---
 rtl/pwm_multi_channel.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel duty compare.
// Duty writes land in shadow registers and move to the active set at period wrap or start.
module pwm_multi_channel #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRE_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [PRE_W-1:0]            prescale,
  input  logic [CNT_W-1:0]            top,
  input  logic [CHANNELS-1:0]         polarity,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(CHANNELS):0]   wr_ch,
  input  logic [CNT_W-1:0]            wr_duty,
  output logic                        wr_err,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_tick
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      top_q, top_d;
  logic [CNT_W-1:0]      shadow_q [CHANNELS];
  logic [CNT_W-1:0]      shadow_d [CHANNELS];
  logic [CNT_W-1:0]      active_q [CHANNELS];
  logic [CNT_W-1:0]      active_d [CHANNELS];
  logic [CHANNELS-1:0]   pwm_out_q, pwm_out_d;
  logic                  period_tick_q, period_tick_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  wr_err_q, wr_err_d;
  logic                  tick;
  logic                  wrap;
  logic                  wr_acc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      top_q         <= '0;
      pwm_out_q     <= '0;
      period_tick_q <= 1'b0;
      wr_ready_q    <= 1'b0;
      wr_err_q      <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      top_q         <= top_d;
      pwm_out_q     <= pwm_out_d;
      period_tick_q <= period_tick_d;
      wr_ready_q    <= wr_ready_d;
      wr_err_q      <= wr_err_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  // Next-state, counters, compare and write port
  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    cnt_d         = cnt_q;
    top_d         = top_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    pwm_out_d     = polarity;
    period_tick_d = 1'b0;
    wr_ready_d    = 1'b1;
    wr_err_d      = 1'b0;
    tick          = 1'b0;
    wrap          = 1'b0;
    wr_acc        = wr_valid & wr_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        pre_cnt_d = '0;
        cnt_d     = '0;
        if (ena) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        active_d  = shadow_q;
        top_d     = top;
        pre_cnt_d = '0;
        cnt_d     = '0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        if (!ena) begin
          // Abandon the current period; outputs fall back to the inactive level
          state_d   = ST_IDLE;
          pre_cnt_d = '0;
          cnt_d     = '0;
        end else begin
          tick = (pre_cnt_q == prescale);
          wrap = tick && (cnt_q == top_q);
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            pwm_out_d[i] = (cnt_q < active_q[i]) ^ polarity[i];
          end
          if (tick) begin
            pre_cnt_d = '0;
            if (wrap) begin
              cnt_d         = '0;
              active_d      = shadow_q;
              top_d         = top;
              period_tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shadow write; the active load above always sees the pre-write shadow
    if (wr_acc) begin
      if (32'(wr_ch) < CHANNELS) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (32'(wr_ch) == i) begin
            shadow_d[i] = wr_duty;
          end
        end
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  assign wr_ready    = wr_ready_q;
  assign wr_err      = wr_err_q;
  assign pwm_out     = pwm_out_q;
  assign period_tick = period_tick_q;

endmodule
